seg_display_scan: RTL and testbench
===================================

# seg_display_scan

Parametrised multiplexed seven-segment display driver for the stopwatch/clock top level. It time-multiplexes `NUM_DIGITS` packed-BCD digits onto a shared active-low cathode bus. It adds per-digit blinking, per-digit decimal points, optional leading-zero blanking and a tear-free frame snapshot. All timing derives from one system clock; refresh and blink rates come from an internal prescaler, with no extra clock domains.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits driven; legal 2..8.
- `REFRESH_DIV`, 100000: clk cycles per digit slot; legal ≥2.
- `BLINK_FRAMES`, 125: full scan frames per blink half-period; legal ≥1.

Ports:
- `clk`  in  1  system clock; the block's only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `digits_bcd`  in  4*NUM_DIGITS  nibble i = digit i; digit 0 is rightmost.
- `blink_mask`  in  NUM_DIGITS  1 = digit blinks.
- `dp_mask`  in  NUM_DIGITS  1 = decimal point lit on that digit.
- `blank_lz`  in  1  1 = enable leading-zero blanking.
- `anode_vec`  out  NUM_DIGITS  active-low digit enables; bit i = digit i.
- `cathode_vec`  out  7  active-low segments {CA,CB,CC,CD,CE,CF,CG}; bit 6 = CA.
- `dp_n`  out  1  active-low decimal point.
- `frame_start`  out  1  one-cycle pulse on each snapshot edge.

## Operation
- Prescaler `pcnt` counts 0..REFRESH_DIV-1. The edge where `pcnt`==REFRESH_DIV-1 is a slot tick, and `pcnt` returns to 0.
- On each tick, scan index `idx` advances; N-1 wraps to 0.
- The tick that moves `idx` to 0 is a frame-start edge:
  - `digits_bcd`, `blink_mask`, `dp_mask` and `blank_lz` are sampled into a snapshot.
  - `frame_start` pulses.
  - Every slot in the frame renders from these sampled values, including slot 0, which uses the values captured on the same edge.
- Blink: a frame counter counts 0..BLINK_FRAMES-1 on frame-start edges. When it wraps, `phase` toggles. The new `phase` applies to the frame beginning on that edge.
  - `phase`=0 means visible; `phase`=1 means blinked digits are hidden.
- Digit decode for the current digit:
  - BCD 0-9 uses the standard patterns, e.g. 0 = 7'b0000001, 8 = 7'b0000000.
  - Values 10-15 display a dash, 7'b1111110.
- Leading-zero blanking:
  - Applies to digit i (i≥1) when snapshot `blank_lz`=1 and digits i..N-1 are all 0.
  - Segments are forced off (7'b1111111).
  - Digit 0 is never blanked.
- Anode rule: active (bit low) for `idx` unless either holds:
  - The digit is blinked-hidden: blink bit set and `phase`=1.
  - The digit is LZ-blanked and its dp bit is 0.
- A blinked-hidden digit also forces `dp_n`=1. Otherwise `dp_n` = ~dp bit of `idx`.
- Non-selected anodes are always 1; at most one anode is low at any time.

## Timing
- Reset values, one edge after `rst` sampled high:
  - `anode_vec` all 1s; `cathode_vec` 7'b1111111; `dp_n` 1; `frame_start` 0.
  - `pcnt` 0; `idx` NUM_DIGITS-1; frame counter 0; `phase` 0; snapshot 0.
- First tick occurs at the REFRESH_DIV-th edge after reset release. That tick is a frame start: digit 0 is driven and `frame_start`=1 for that cycle.
- All outputs are registered and change only on tick edges or on reset; `frame_start` returns to 0 on the following edge.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. Full blink period = 2*BLINK_FRAMES frames.
- Input changes mid-frame have no visible effect until the next frame-start edge.
- `rst` asserted mid-frame takes priority over a coincident tick. Outputs blank on the next edge and the scan restarts as above.
- Counter widths are sized with `$clog2`. No counter overflows for any legal parameter value.

## Structure
- Shared package `seg_pkg`:
  - Segment constants `SEG_0`..`SEG_9`, `SEG_DASH`, `SEG_OFF` (7-bit, active-low, CA at bit 6).
  - The digit-nibble width constant.
- Sub-module `bcd_to_seg`: combinational 4-bit to 7-bit decoder using `seg_pkg`, instantiated once on the muxed digit.
- Prescaler, scan index, snapshot, blink logic and output registers live in `seg_display_scan`.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2.
- Scan order: `digits_bcd`=16'h1234 after reset.
  - Ticks every 4 cycles; anodes 1110, 1101, 1011, 0111 repeat.
  - Cathodes are 4, 3, 2, 1 patterns.
  - `frame_start` pulses every 16 cycles.
- Snapshot: change to 16'h5678 while digit 1 is displayed.
  - Digits 2 and 3 still show 2, 1.
  - The next frame shows 8, 7, 6, 5.
- Blink: `blink_mask`=4'b0011.
  - Digits 0-1 visible for 2 frames, then anodes held high for 2 frames.
  - Digits 2-3 are unaffected.
- Leading-zero blanking: 16'h0040 with `blank_lz`=1.
  - Digits 3 and 2 have anodes high; digit 1 shows 4; digit 0 shows 0.
  - Setting `dp_mask`=4'b0100 re-enables anode 2 with `cathode_vec`=7'b1111111 and `dp_n`=0.
- Invalid BCD: digit nibble 4'hC displays 7'b1111110.
- Reset mid-frame: `rst` held 1 cycle during digit 2.
  - All outputs blank on the next edge.
  - Digit 0 reappears 4 edges after release, with `frame_start`=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment patterns are active-low, ordered {CA..CG} with CA at bit 6.
package seg_pkg;

  localparam int NIB_W = 4;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Ports: bcd_i (4-bit digit), seg_o (7-bit {CA..CG}); 10-15 show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] bcd_i,
  output logic [6:0]       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Multiplexed seven-segment driver: prescaled scan, frame snapshot,
// blink, decimal points and leading-zero blanking.
// Ports: clk, rst (sync, high); digits_bcd, blink_mask, dp_mask, blank_lz in;
// anode_vec, cathode_vec, dp_n (all active-low), frame_start out.
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NIB_W*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  input  logic [NUM_DIGITS-1:0]       dp_mask,
  input  logic                        blank_lz,
  output logic [NUM_DIGITS-1:0]       anode_vec,
  output logic [6:0]                  cathode_vec,
  output logic                        dp_n,
  output logic                        frame_start
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pcnt_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  logic [NIB_W*NUM_DIGITS-1:0] snap_dig_q;
  logic [NUM_DIGITS-1:0]       snap_blink_q;
  logic [NUM_DIGITS-1:0]       snap_dp_q;
  logic                        snap_lz_q;

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]            cath_q, cath_d;
  logic                  dp_q, dp_d;
  logic                  fs_q;

  logic tick, wrap, fstart;

  assign tick   = (pcnt_q == PMAX);
  assign wrap   = (idx_q == IMAX);
  assign fstart = tick & wrap;

  // Slot 0 renders from the values captured on the same edge,
  // so the render path bypasses the snapshot registers then.
  logic [NIB_W*NUM_DIGITS-1:0] eff_dig;
  logic [NUM_DIGITS-1:0]       eff_blink;
  logic [NUM_DIGITS-1:0]       eff_dp;
  logic                        eff_lz;

  assign eff_dig   = fstart ? digits_bcd : snap_dig_q;
  assign eff_blink = fstart ? blink_mask : snap_blink_q;
  assign eff_dp    = fstart ? dp_mask    : snap_dp_q;
  assign eff_lz    = fstart ? blank_lz   : snap_lz_q;

  always_comb begin
    idx_d = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (fstart) begin
      if (fcnt_q == FMAX) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  logic [NIB_W-1:0]      nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  acc_zero;

  // upper_zero[i]: digits i..N-1 of the frame are all zero.
  always_comb begin
    upper_zero = '0;
    acc_zero   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]        = eff_dig[i*NIB_W +: NIB_W];
      acc_zero      = acc_zero & (nib[i] == '0);
      upper_zero[i] = acc_zero;
    end
  end

  logic [NIB_W-1:0] cur_nib;
  logic [6:0]       cur_seg;
  logic             lz_blank;
  logic             hidden;

  assign cur_nib = nib[idx_d];

  bcd_to_seg u_dec (
    .bcd_i (cur_nib),
    .seg_o (cur_seg)
  );

  always_comb begin
    lz_blank = eff_lz & (idx_d != '0) & upper_zero[idx_d];
    hidden   = eff_blink[idx_d] & phase_d;
    anode_d  = '1;
    if (!(hidden | (lz_blank & ~eff_dp[idx_d]))) begin
      anode_d[idx_d] = 1'b0;
    end
    cath_d = lz_blank ? SEG_OFF : cur_seg;
    dp_d   = hidden ? 1'b1 : ~eff_dp[idx_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q       <= '0;
      idx_q        <= IMAX;
      fcnt_q       <= '0;
      phase_q      <= 1'b0;
      snap_dig_q   <= '0;
      snap_blink_q <= '0;
      snap_dp_q    <= '0;
      snap_lz_q    <= 1'b0;
      anode_q      <= '1;
      cath_q       <= SEG_OFF;
      dp_q         <= 1'b1;
      fs_q         <= 1'b0;
    end else begin
      pcnt_q  <= tick ? '0 : pcnt_q + 1'b1;
      idx_q   <= idx_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
      fs_q    <= fstart;
      if (fstart) begin
        snap_dig_q   <= digits_bcd;
        snap_blink_q <= blink_mask;
        snap_dp_q    <= dp_mask;
        snap_lz_q    <= blank_lz;
      end
      if (tick) begin
        anode_q <= anode_d;
        cath_q  <= cath_d;
        dp_q    <= dp_d;
      end
    end
  end

  assign anode_vec   = anode_q;
  assign cathode_vec = cath_q;
  assign dp_n        = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Randomized scoreboard bench for seg_display_scan.
// Reference model derives slot/frame/phase from elapsed cycle counts.
module tb_seg_display_scan;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] digits_bcd;
  logic [N-1:0]  blink_mask;
  logic [N-1:0]  dp_mask;
  logic          blank_lz;
  logic [N-1:0]  anode_vec;
  logic [6:0]    cathode_vec;
  logic          dp_n;
  logic          frame_start;

  seg_display_scan #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_bcd  (digits_bcd),
    .blink_mask  (blink_mask),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .anode_vec   (anode_vec),
    .cathode_vec (cathode_vec),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   ca;
    logic         dp;
    logic         fs;
    logic         ca_care;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111110;
    endcase
  endfunction

  // Reference model state
  int           k_cyc;
  int           n_ticks;
  int           ph;
  logic [4*N-1:0] s_dig;
  logic [N-1:0] s_blk;
  logic [N-1:0] s_dp;
  logic         s_lz;
  exp_t         cur;

  task automatic model_step();
    int  i, f;
    bit  lz, hid;
    if (rst) begin
      k_cyc   = 0;
      n_ticks = 0;
      cur.an  = '1;
      cur.ca  = 7'h7F;
      cur.dp  = 1'b1;
      cur.fs  = 1'b0;
      cur.ca_care = 1'b1;
    end else begin
      k_cyc++;
      cur.fs = 1'b0;
      if (k_cyc % R == 0) begin
        n_ticks++;
        i = (n_ticks - 1) % N;
        if (i == 0) begin
          s_dig  = digits_bcd;
          s_blk  = blink_mask;
          s_dp   = dp_mask;
          s_lz   = blank_lz;
          f      = (n_ticks - 1) / N;
          ph     = ((f + 1) / BF) % 2;
          cur.fs = 1'b1;
        end
        lz  = s_lz && (i >= 1) && ((s_dig >> (4 * i)) == 0);
        hid = s_blk[i] && (ph == 1);
        cur.an = '1;
        if (!(hid || (lz && !s_dp[i]))) cur.an[i] = 1'b0;
        cur.ca = lz ? 7'h7F : seg_of(s_dig[4*i +: 4]);
        cur.ca_care = !hid;
        cur.dp = hid ? 1'b1 : !s_dp[i];
      end
    end
    exp_q.push_back(cur);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
          e = exp_q.pop_front();
          check("anode_vec", 32'(anode_vec), 32'(e.an));
          check("dp_n", 32'(dp_n), 32'(e.dp));
          check("frame_start", 32'(frame_start), 32'(e.fs));
          if (e.ca_care)
            check("cathode_vec", 32'(cathode_vec), 32'(e.ca));
        end
      end
    end
  end

  function automatic logic [4*N-1:0] rand_digits();
    logic [4*N-1:0] d;
    d = '0;
    for (int j = 0; j < N; j++) begin
      if ($urandom_range(0, 9) < 4) d[4*j +: 4] = 4'd0;
      else d[4*j +: 4] = 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  initial begin
    rst        = 1'b1;
    digits_bcd = 16'h1234;
    blink_mask = '0;
    dp_mask    = '0;
    blank_lz   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    blink_mask = 4'b0011;
    repeat (80) @(negedge clk);
    digits_bcd = 16'h0040;
    blink_mask = '0;
    blank_lz   = 1'b1;
    repeat (40) @(negedge clk);
    dp_mask = 4'b0100;
    repeat (40) @(negedge clk);
    digits_bcd = 16'h5C78;
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 19) == 0) digits_bcd = rand_digits();
      if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) dp_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
